mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter onto a single shared cache port.
// Data normally wins; a pending fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         if_enable,
    input  logic [63:0]  if_addr,
    input  logic         if_flush,
    output logic [511:0] if_data,
    output logic         if_done,
    input  logic         d_enable,
    input  logic         d_write,
    input  logic [63:0]  d_addr,
    input  logic [511:0] d_wdata,
    output logic [511:0] d_rdata,
    output logic         d_done,
    output logic         m_enable,
    output logic         m_write,
    output logic [63:0]  m_addr,
    output logic [511:0] m_wdata,
    input  logic [511:0] m_rdata,
    input  logic         m_done
);
    localparam int CW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef struct packed {
        logic [63:0]  addr;
        logic         write;
        logic [511:0] wdata;
    } req_t;

    state_t        state, state_nxt;
    logic          f_pend, d_pend;
    logic [63:0]   f_addr;
    req_t          d_req;
    logic          owner_d;
    logic          squash;
    logic [CW-1:0] starve;

    logic fin, f_avail, f_busy, d_busy, f_take, d_take, grant_d, grant_f;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        fin       = (state == WAIT) && m_done;
        // A flush removes the fetch slot before arbitration sees it.
        f_avail   = f_pend && !if_flush;
        // A transaction stops blocking its port on the edge its m_done arrives.
        f_busy    = (state == WAIT) && !owner_d && !squash && !m_done;
        d_busy    = (state == WAIT) && owner_d && !m_done;
        f_take    = if_enable && (if_flush || (!f_pend && !f_busy));
        d_take    = d_enable && !d_pend && !d_busy;
        case (state)
            IDLE: begin
                if (d_pend && !(f_avail && starve == LIMIT)) grant_d = 1'b1;
                else if (f_avail)                            grant_f = 1'b1;
                if (grant_d || grant_f) state_nxt = WAIT;
            end
            WAIT: if (m_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_pend   <= 1'b0;
            f_addr   <= '0;
            d_pend   <= 1'b0;
            d_req    <= '0;
            owner_d  <= 1'b0;
            squash   <= 1'b0;
            starve   <= '0;
            m_enable <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_data  <= '0;
            if_done  <= 1'b0;
            d_rdata  <= '0;
            d_done   <= 1'b0;
        end else begin
            m_enable <= grant_d || grant_f;
            if_done  <= 1'b0;
            d_done   <= 1'b0;

            if (f_take)                   f_pend <= 1'b1;
            else if (grant_f || if_flush) f_pend <= 1'b0;
            if (f_take) f_addr <= if_addr;

            if (d_take)       d_pend <= 1'b1;
            else if (grant_d) d_pend <= 1'b0;
            if (d_take) d_req <= '{addr: d_addr, write: d_write, wdata: d_wdata};

            if (grant_f || !f_avail)                    starve <= '0;
            else if (grant_d && starve != LIMIT)        starve <= starve + 1'b1;

            if (grant_d) begin
                owner_d <= 1'b1;
                m_addr  <= d_req.addr & ~64'd63;
                m_write <= d_req.write;
                m_wdata <= d_req.wdata;
            end else if (grant_f) begin
                owner_d <= 1'b0;
                m_addr  <= f_addr & ~64'd63;
                m_write <= 1'b0;
                m_wdata <= '0;
            end

            if (grant_f || (fin && !owner_d)) squash <= 1'b0;
            else if (if_flush && f_busy)      squash <= 1'b1;

            if (fin) begin
                if (owner_d) begin
                    d_done <= 1'b1;
                    if (!d_req.write) d_rdata <= m_rdata;
                end else if (!squash && !if_flush) begin
                    if_done <= 1'b1;
                    if_data <= m_rdata;
                end
            end
        end
    end
endmodule
